// File: rtl/fpu_pkg.sv
// Shared definitions for the floating-point datapath stages.
// Contents:
//   EXP_BIAS, EXP_MAX    - single-precision exponent constants
//   norm_state_t         - control states of the normalize/round stage
//   CARRY_B .. S_B       - bit positions inside the 28-bit aligned mantissa bus
//   QNAN / INF_POS / INF_NEG - packed special-value patterns
package fpu_pkg;

  localparam int          EXP_BIAS = 127;
  localparam logic [7:0]  EXP_MAX  = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } norm_state_t;

  // Mantissa bus layout: [27]=carry, [26]=hidden, [25:3]=fraction,
  // [2]=guard, [1]=round, [0]=sticky.
  localparam int CARRY_B  = 27;
  localparam int HIDDEN_B = 26;
  localparam int LSB_B    = 3;
  localparam int G_B      = 2;
  localparam int R_B      = 1;
  localparam int S_B      = 0;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] INF_POS = 32'h7F80_0000;
  localparam logic [31:0] INF_NEG = 32'hFF80_0000;

endpackage

// File: rtl/fpu_round_rne.sv
// Round-to-nearest-even incrementer (purely combinational).
// Ports:
//   sig       in  SIG_W  significand {hidden, fraction}; sig[0] is the lsb
//   g, r, s   in  1      guard, round and sticky bits below the lsb
//   sig_rnd   out SIG_W  rounded significand
//   carry     out 1      rounding overflowed the significand (all ones + 1)
module fpu_round_rne #(
  parameter int SIG_W = 24
) (
  input  logic [SIG_W-1:0] sig,
  input  logic             g,
  input  logic             r,
  input  logic             s,
  output logic [SIG_W-1:0] sig_rnd,
  output logic             carry
);

  logic             inc;
  logic [SIG_W:0]   sum;

  // Round up when above half, or exactly half and the lsb is odd.
  assign inc     = g & (r | s | sig[0]);
  assign sum     = {1'b0, sig} + {{SIG_W{1'b0}}, inc};
  assign sig_rnd = sum[SIG_W-1:0];
  assign carry   = sum[SIG_W];

endmodule

// File: rtl/fpu_normalize_round.sv
// Post-addition normalize and round stage of the FP adder.
// Takes the raw aligned mantissa sum, the larger exponent and the result sign,
// renormalizes one bit per cycle, rounds to nearest-even and packs an IEEE-754
// single-precision result.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   in_valid/ready  input handshake; ready only while idle
//   in_sign         result sign from the adder
//   in_exp          larger exponent from the align stage
//   in_mant         aligned mantissa sum (carry, hidden, fraction, g, r, s)
//   out_valid/ready output handshake; result and flags held until accepted
//   out_result      packed {sign, exp, frac}
//   out_overflow    result saturated to infinity
//   out_underflow   result flushed to signed zero
//   out_zero        exact zero result
module fpu_normalize_round
  import fpu_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sign,
  input  logic [EXP_W-1:0]          in_exp,
  input  logic [FRAC_W+4:0]         in_mant,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+FRAC_W:0]     out_result,
  output logic                      out_overflow,
  output logic                      out_underflow,
  output logic                      out_zero
);

  localparam int MANT_W = FRAC_W + 5;
  localparam int SIG_W  = FRAC_W + 1;
  localparam int RES_W  = EXP_W + FRAC_W + 1;
  // Two extra bits: one for +1 past the maximum, one for sign below zero.
  localparam int EXPI_W = EXP_W + 2;
  localparam logic signed [EXPI_W-1:0] EXP_ONE = EXPI_W'(1);
  localparam logic signed [EXPI_W-1:0] EXP_TOP = EXPI_W'((1 << EXP_W) - 1);

  norm_state_t               state_reg, state_next;
  logic                      sign_reg, sign_next;
  logic signed [EXPI_W-1:0]  exp_reg, exp_next;
  logic [MANT_W-1:0]         mant_reg, mant_next;
  logic [RES_W-1:0]          result_reg, result_next;
  logic                      ovf_reg, ovf_next;
  logic                      unf_reg, unf_next;
  logic                      zero_reg, zero_next;

  logic [SIG_W-1:0]          sig_rnd;
  logic                      rnd_carry;
  logic signed [EXPI_W-1:0]  exp_rnd;

  fpu_round_rne #(.SIG_W(SIG_W)) u_round (
    .sig     (mant_reg[HIDDEN_B:LSB_B]),
    .g       (mant_reg[G_B]),
    .r       (mant_reg[R_B]),
    .s       (mant_reg[S_B]),
    .sig_rnd (sig_rnd),
    .carry   (rnd_carry)
  );

  // A rounding carry leaves sig_rnd all zeros, so the fraction is already 0.
  assign exp_rnd = exp_reg + (rnd_carry ? EXP_ONE : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      sign_reg   <= 1'b0;
      exp_reg    <= '0;
      mant_reg   <= '0;
      result_reg <= '0;
      ovf_reg    <= 1'b0;
      unf_reg    <= 1'b0;
      zero_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      sign_reg   <= sign_next;
      exp_reg    <= exp_next;
      mant_reg   <= mant_next;
      result_reg <= result_next;
      ovf_reg    <= ovf_next;
      unf_reg    <= unf_next;
      zero_reg   <= zero_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    sign_next   = sign_reg;
    exp_next    = exp_reg;
    mant_next   = mant_reg;
    result_next = result_reg;
    ovf_next    = ovf_reg;
    unf_next    = unf_reg;
    zero_next   = zero_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          sign_next  = in_sign;
          exp_next   = $signed({2'b00, in_exp});
          mant_next  = in_mant;
          state_next = NORM;
        end
      end

      NORM: begin
        if (mant_reg == '0) begin
          result_next = '0;
          zero_next   = 1'b1;
          state_next  = DONE;
        end else if (mant_reg[CARRY_B]) begin
          // Shift right once; OR the dropped bit into sticky.
          mant_next  = {1'b0, mant_reg[MANT_W-1:2], mant_reg[1] | mant_reg[0]};
          exp_next   = exp_reg + EXP_ONE;
          state_next = ROUND;
        end else if (mant_reg[HIDDEN_B]) begin
          state_next = ROUND;
        end else if (exp_reg <= EXP_ONE) begin
          result_next = {sign_reg, {(RES_W-1){1'b0}}};
          unf_next    = 1'b1;
          state_next  = DONE;
        end else begin
          mant_next = {mant_reg[MANT_W-2:0], 1'b0};
          exp_next  = exp_reg - EXP_ONE;
        end
      end

      ROUND: begin
        if (exp_rnd >= EXP_TOP) begin
          result_next = {sign_reg, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          ovf_next    = 1'b1;
        end else begin
          result_next = {sign_reg, exp_rnd[EXP_W-1:0], sig_rnd[FRAC_W-1:0]};
        end
        state_next = DONE;
      end

      DONE: begin
        if (out_ready) begin
          ovf_next   = 1'b0;
          unf_next   = 1'b0;
          zero_next  = 1'b0;
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign in_ready      = (state_reg == IDLE);
  assign out_valid     = (state_reg == DONE);
  assign out_result    = result_reg;
  assign out_overflow  = ovf_reg;
  assign out_underflow = unf_reg;
  assign out_zero      = zero_reg;

endmodule
